// File: rtl/act_pkg.sv
// act_pkg: shared constants and state type for the activation stream reader.
package act_pkg;
   localparam int ACT_DATA_WIDTH = 16;
   localparam int ACT_NUM_ELEMENTS = 16;
   localparam int ACT_IDX_W = $clog2(ACT_NUM_ELEMENTS);
   typedef enum logic {IDLE, STREAM} act_stream_state_t;
endpackage

// File: rtl/act_rise_detect.sv
// act_rise_detect: registered rising-edge detector for level-held done signals.
module act_rise_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);
   logic level_q;
   always_ff @(posedge clk)
      if (reset) level_q <= RESET_VAL;
      else level_q <= level;
   assign rise = level & ~level_q;
endmodule

// File: rtl/act_stream_out.sv
// act_stream_out: captures a packed result vector on done rise and streams it one element per beat.
// Optional ACT_STREAM_PERF_EN adds saturating stall_cnt and vec_cnt outputs.
module act_stream_out
   import act_pkg::*;
#(
   parameter int NUM_ELEMENTS = ACT_NUM_ELEMENTS,
   parameter int DATA_WIDTH = ACT_DATA_WIDTH,
   localparam int IW = $clog2(NUM_ELEMENTS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in_vec,
   input  logic                               in_done,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
   output logic [IW-1:0]                      out_index,
   output logic                               busy,
   output logic                               vec_done,
   output logic                               overflow,
   input  logic                               clear_err
`ifdef ACT_STREAM_PERF_EN
   ,
   output logic [31:0]                        stall_cnt,
   output logic [15:0]                        vec_cnt
`endif
);
   act_stream_state_t state, state_n;
   logic [NUM_ELEMENTS*DATA_WIDTH-1:0] buf_q;
   logic [IW-1:0] index;
   logic load, fire, last, final_beat;
   // Reset value 1 so a done already high at reset release is not taken as a new vector.
   act_rise_detect #(.RESET_VAL(1'b1)) u_rise (
      .clk(clk), .reset(reset), .level(in_done), .rise(load)
   );
   always_comb begin
      busy = state == STREAM;
      last = index == IW'(NUM_ELEMENTS - 1);
      fire = busy & out_ready;
      final_beat = fire & last;
      out_valid = busy;
      out_index = index;
      out_last = busy & last;
      out_data = busy ? buf_q[32'(index) * DATA_WIDTH +: DATA_WIDTH] : '0;
      state_n = (state == IDLE) ? (load ? STREAM : IDLE) : ((final_beat & ~load) ? IDLE : STREAM);
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk)
      if (reset) begin
         buf_q <= '0;
         index <= '0;
         vec_done <= 1'b0;
         overflow <= 1'b0;
      end else begin
         vec_done <= final_beat;
         if (load & (~busy | final_beat)) begin
            buf_q <= in_vec;
            index <= '0;
         end else if (fire) index <= last ? '0 : index + 1'b1;
         if (load & busy & ~final_beat) overflow <= 1'b1;
         else if (clear_err) overflow <= 1'b0;
      end
`ifdef ACT_STREAM_PERF_EN
   always_ff @(posedge clk)
      if (reset) begin
         stall_cnt <= '0;
         vec_cnt <= '0;
      end else begin
         if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
         if (vec_done & ~&vec_cnt) vec_cnt <= vec_cnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_act_stream_out.sv
// tb_act_stream_out: directed self-checking bench for act_stream_out (covers ACT_STREAM_PERF_EN when defined).
module tb_act_stream_out;
   logic clk = 0, reset = 1, in_done = 0, out_ready = 0, clear_err = 0;
   logic [255:0] in_vec = '0;
   logic [15:0] out_data;
   logic [3:0] out_index;
   logic out_valid, out_last, busy, vec_done, overflow;
`ifdef ACT_STREAM_PERF_EN
   logic [31:0] stall_cnt;
   logic [15:0] vec_cnt;
`endif
   int errors = 0, checks = 0, pulses = 0, p0 = 0, s = 0;
   logic [255:0] va, vb, vc, vd, ve, vf, vg;
   act_stream_out dut (
      .clk(clk), .reset(reset), .in_vec(in_vec), .in_done(in_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_index(out_index), .busy(busy),
      .vec_done(vec_done), .overflow(overflow), .clear_err(clear_err)
`ifdef ACT_STREAM_PERF_EN
      , .stall_cnt(stall_cnt), .vec_cnt(vec_cnt)
`endif
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (vec_done) pulses++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [255:0] mk(input logic [15:0] base, input logic [15:0] step);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = base + step * 16'(i);
      return v;
   endfunction
   // Streams one vector, optionally with 1,0,0,1 backpressure and a done rise injected at beat inj.
   task automatic stream_vec(input logic [255:0] vec, input bit bp, input int inj,
                             input logic [255:0] vec2, output int stalls);
      int k = 0, c = 0;
      stalls = 0;
      while (k < 16 && c < 200) begin
         out_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
         if (k == inj) begin
            in_vec = vec2;
            in_done = 1;
         end
         check("valid", out_valid, 1);
         check("data", out_data, vec[k*16 +: 16]);
         check("index", out_index, k);
         check("last", out_last, k == 15);
         if (k > 0) check("vdone_lo", vec_done, 0);
         if (out_ready) k++;
         else stalls++;
         c++;
         tick();
      end
      if (k < 16) check("stream_timeout", k, 16);
      check("vdone", vec_done, 1);
   endtask
   initial begin
      va = mk(16'h0100, 16'h0001);
      vb = mk(16'hBEE0, 16'h0003);
      vc = mk(16'h1234, 16'h0111);
      vd = mk(16'hF000, 16'h0101);
      ve = mk(16'h0A0A, 16'h0010);
      vf = mk(16'h5500, 16'h0002);
      vg = mk(16'h8001, 16'h0400);
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_index", out_index, 0);
      check("rst_vdone", vec_done, 0);
      check("rst_ovf", overflow, 0);
      reset = 0;
      tick();
      // basic stream
      in_vec = va;
      in_done = 1;
      tick();
      in_done = 0;
      stream_vec(va, 0, -1, '0, s);
      tick();
      check("basic_vdone_end", vec_done, 0);
      check("basic_busy", busy, 0);
      check("basic_valid", out_valid, 0);
      // backpressure
      out_ready = 1;
      in_vec = vg;
      in_done = 1;
      tick();
      in_done = 0;
      stream_vec(vg, 1, -1, '0, s);
`ifdef ACT_STREAM_PERF_EN
      check("stall_cnt", stall_cnt, 16);
`endif
      tick();
      // level-held done
      p0 = pulses;
      in_vec = ve;
      in_done = 1;
      tick();
      stream_vec(ve, 0, -1, '0, s);
      repeat (22) tick();
      check("level_valid", out_valid, 0);
      check("level_ovf", overflow, 0);
      check("level_pulses", pulses - p0, 1);
      in_done = 0;
      tick();
      // overflow on a drop mid-stream
      in_vec = va;
      in_done = 1;
      tick();
      in_done = 0;
      stream_vec(va, 0, 5, vb, s);
      in_done = 0;
      check("ovf_set", overflow, 1);
      clear_err = 1;
      tick();
      clear_err = 0;
      check("ovf_clr", overflow, 0);
      // back-to-back on the final beat
      p0 = pulses;
      in_vec = vc;
      in_done = 1;
      tick();
      in_done = 0;
      stream_vec(vc, 0, 15, vd, s);
      in_done = 0;
      stream_vec(vd, 0, -1, '0, s);
      tick();
      check("b2b_pulses", pulses - p0, 2);
      check("b2b_ovf", overflow, 0);
      check("b2b_busy", busy, 0);
`ifdef ACT_STREAM_PERF_EN
      check("vec_cnt", vec_cnt, 6);
`endif
      // reset mid-stream with done held high
      in_vec = vf;
      in_done = 1;
      tick();
      out_ready = 1;
      repeat (7) tick();
      check("pre_rst_data", out_data, vf[7*16 +: 16]);
      p0 = pulses;
      reset = 1;
      tick();
      check("mrst_valid", out_valid, 0);
      check("mrst_index", out_index, 0);
      check("mrst_busy", busy, 0);
      check("mrst_data", out_data, 0);
      check("mrst_vdone", vec_done, 0);
      reset = 0;
      repeat (3) tick();
      check("held_done_valid", out_valid, 0);
      check("mrst_pulses", pulses - p0, 0);
      in_done = 0;
      tick();
      in_done = 1;
      tick();
      in_done = 0;
      stream_vec(vf, 0, -1, '0, s);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
